// File: rtl/merged_word_splitter.sv
// Splits one merged word (two byte-packed, MSB-justified fields) into up to two
// MSB-justified, zero-padded output fields, one per output handshake.
module merged_word_splitter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [2*DATA_WIDTH-1:0]   dataIn,
  input  logic [2*TAG_WIDTH-1:0]    inTag,
  input  logic [LEN_WIDTH-1:0]      inLen,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [DATA_WIDTH-1:0]     dataOut,
  output logic [TAG_WIDTH-1:0]      outTag,
  output logic [LEN_WIDTH-1:0]      outLen,
  output logic                      outLast,
  output logic                      lenErr
);

  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, EMIT0, EMIT1} state_t;

  function automatic logic [LEN_WIDTH-1:0] tag_len(input logic [TAG_WIDTH-1:0] t);
    case (t)
      2'b01:   return LEN_WIDTH'(1);
      2'b10:   return LEN_WIDTH'(2);
      2'b11:   return LEN_WIDTH'(4);
      default: return '0;
    endcase
  endfunction

  // Zero every byte at or beyond len, counting bytes from the MSB end.
  function automatic logic [DATA_WIDTH-1:0] mask_bytes(input logic [DATA_WIDTH-1:0] f,
                                                       input logic [LEN_WIDTH-1:0]  len);
    logic [DATA_WIDTH-1:0] r;
    r = f;
    for (int i = 0; i < NBYTES; i++) begin
      if (LEN_WIDTH'(i) >= len) r[DATA_WIDTH-1-8*i -: 8] = 8'h00;
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] field1_of(input logic [2*DATA_WIDTH-1:0] w,
                                                      input logic [LEN_WIDTH-1:0]    len0);
    logic [2*DATA_WIDTH-1:0] s;
    s = w << {len0, 3'b000};
    return s[2*DATA_WIDTH-1:DATA_WIDTH];
  endfunction

  state_t                    state_q, state_d;
  logic [2*DATA_WIDTH-1:0]   wbuf_q, wbuf_d;
  logic [TAG_WIDTH-1:0]      tag0_q, tag0_d, tag1_q, tag1_d;
  logic [LEN_WIDTH-1:0]      len0_q, len0_d, len1_q, len1_d;
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic                      last_q, last_d;
  logic                      len_err_q, len_err_d;

  logic                      accept;
  logic [LEN_WIDTH-1:0]      in_len0, in_len1;

  assign inReady  = (state_q == IDLE);
  assign accept   = inValid && inReady;
  assign in_len0  = tag_len(inTag[2*TAG_WIDTH-1:TAG_WIDTH]);
  assign in_len1  = tag_len(inTag[TAG_WIDTH-1:0]);

  assign wbuf_d = accept ? dataIn  : wbuf_q;
  assign tag0_d = accept ? inTag[2*TAG_WIDTH-1:TAG_WIDTH] : tag0_q;
  assign tag1_d = accept ? inTag[TAG_WIDTH-1:0] : tag1_q;
  assign len0_d = accept ? in_len0 : len0_q;
  assign len1_d = accept ? in_len1 : len1_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_len0 != '0)      state_d = EMIT0;
          else if (in_len1 != '0) state_d = EMIT1;
          else                    state_d = IDLE;
        end
      end
      EMIT0:   if (outReady) state_d = (len1_q != '0) ? EMIT1 : IDLE;
      EMIT1:   if (outReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state and next buffer.
  always_comb begin
    valid_d   = 1'b0;
    data_d    = data_q;
    tag_d     = tag_q;
    len_d     = len_q;
    last_d    = last_q;
    len_err_d = accept && (inLen != LEN_WIDTH'(in_len0 + in_len1));
    case (state_d)
      EMIT0: begin
        valid_d = 1'b1;
        data_d  = mask_bytes(wbuf_d[2*DATA_WIDTH-1:DATA_WIDTH], len0_d);
        tag_d   = tag0_d;
        len_d   = len0_d;
        last_d  = (len1_d == '0);
      end
      EMIT1: begin
        valid_d = 1'b1;
        data_d  = mask_bytes(field1_of(wbuf_d, len0_d), len1_d);
        tag_d   = tag1_d;
        len_d   = len1_d;
        last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      data_q    <= '0;
      tag_q     <= '0;
      len_q     <= '0;
      last_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      len_q     <= len_d;
      last_q    <= last_d;
      len_err_q <= len_err_d;
    end
  end

  // The held word needs no reset: it is only read while in an EMIT state.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
    tag0_q <= tag0_d;
    tag1_q <= tag1_d;
    len0_q <= len0_d;
    len1_q <= len1_d;
  end

  assign outValid = valid_q;
  assign dataOut  = data_q;
  assign outTag   = tag_q;
  assign outLen   = len_q;
  assign outLast  = last_q;
  assign lenErr   = len_err_q;

endmodule

// File: tb/tb_merged_word_splitter.sv
// Scoreboard bench for merged_word_splitter: a byte-array reference model fills
// an expected-field queue; a negedge monitor pops and compares on each handshake.
module tb_merged_word_splitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [63:0] dataIn = '0;
  logic [3:0]  inTag = '0;
  logic [7:0]  inLen = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] dataOut;
  logic [1:0]  outTag;
  logic [7:0]  outLen;
  logic        outLast;
  logic        lenErr;

  merged_word_splitter #(.DATA_WIDTH(32), .TAG_WIDTH(2), .LEN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .inTag(inTag), .inLen(inLen),
    .outValid(outValid), .outReady(outReady), .dataOut(dataOut),
    .outTag(outTag), .outLen(outLen), .outLast(outLast), .lenErr(lenErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  t;
    logic [7:0]  l;
    logic        last;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   le_cyc = -1;
  logic le_val = 1'b0;
  bit   rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tlen(input logic [1:0] t);
    case (t)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 4;
    endcase
  endfunction

  // Reference: view the word as 8 bytes, field0 = first len0 bytes, field1 = next len1.
  task automatic model_push(input logic [63:0] d, input logic [3:0] t);
    logic [7:0]  b[8];
    logic [31:0] f;
    int          l0, l1;
    exp_t        e;
    for (int i = 0; i < 8; i++) b[i] = d[63-8*i -: 8];
    l0 = tlen(t[3:2]);
    l1 = tlen(t[1:0]);
    if (l0 != 0) begin
      f = '0;
      for (int j = 0; j < l0; j++) f[31-8*j -: 8] = b[j];
      e.d = f; e.t = t[3:2]; e.l = 8'(l0); e.last = (l1 == 0);
      expq.push_back(e);
    end
    if (l1 != 0) begin
      f = '0;
      for (int j = 0; j < l1; j++) f[31-8*j -: 8] = b[l0+j];
      e.d = f; e.t = t[1:0]; e.l = 8'(l1); e.last = 1'b1;
      expq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("lenErr", 64'(lenErr), (cyc == le_cyc) ? 64'(le_val) : 64'd0);
      if (outValid && outReady) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_field: got data %0h tag %0h len %0d, expected no field",
                   dataOut, outTag, outLen);
        end else begin
          e = expq.pop_front();
          chk("field_data", 64'(dataOut), 64'(e.d));
          chk("field_tag",  64'(outTag),  64'(e.t));
          chk("field_len",  64'(outLen),  64'(e.l));
          chk("field_last", 64'(outLast), 64'(e.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) outReady = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] t, input logic [7:0] l,
                      output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    dataIn = d; inTag = t; inLen = l; inValid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = inReady;
      tick();
    end
    inValid = 1'b0;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: word never accepted, expected acceptance within 200 cycles");
    end else begin
      acc_cyc = cyc;
      le_cyc  = cyc;
      le_val  = (int'(l) != tlen(t[3:2]) + tlen(t[1:0]));
      model_push(d, t);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && expq.size() > 0; k++) tick();
    if (expq.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d fields outstanding, expected 0", expq.size());
    end
    tick();
  endtask

  task automatic rand_word(output logic [63:0] d, output logic [3:0] t, output logic [7:0] l);
    d = {$urandom, $urandom};
    t = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) l = 8'($urandom_range(0, 9));
    else l = 8'(tlen(t[3:2]) + tlen(t[1:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, first_acc, last_acc, exp_span;
    logic [63:0] d;
    logic [3:0]  t;
    logic [7:0]  l;

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_dataOut",  64'(dataOut),  64'd0);
    chk("rst_outTag",   64'(outTag),   64'd0);
    chk("rst_outLen",   64'(outLen),   64'd0);
    chk("rst_outLast",  64'(outLast),  64'd0);
    chk("rst_lenErr",   64'(lenErr),   64'd0);
    chk("rst_inReady",  64'(inReady),  64'd1);
    tick();

    // Two fields, first valid one cycle after capture
    send(64'h4567_89AB_CDEF_0000, 4'b1011, 8'd6, a);
    @(negedge clk);
    chk("t1_valid0", 64'(outValid), 64'd1);
    chk("t1_data0",  64'(dataOut),  64'h4567_0000);
    chk("t1_last0",  64'(outLast),  64'd0);
    tick();
    @(negedge clk);
    chk("t1_data1",  64'(dataOut),  64'h89AB_CDEF);
    chk("t1_last1",  64'(outLast),  64'd1);
    drain();

    // Only field1 present
    send(64'h7700_0000_0000_0000, 4'b0001, 8'd1, a);
    @(negedge clk);
    chk("t2_data", 64'(dataOut), 64'h7700_0000);
    chk("t2_tag",  64'(outTag),  64'd1);
    chk("t2_last", 64'(outLast), 64'd1);
    tick();
    @(negedge clk);
    chk("t2_idle_valid", 64'(outValid), 64'd0);
    drain();

    // Empty word dropped, then a length-mismatched word
    send(64'hDEAD_BEEF_0123_4567, 4'b0000, 8'd0, a);
    @(negedge clk);
    chk("t3_empty_valid",   64'(outValid), 64'd0);
    chk("t3_empty_inReady", 64'(inReady),  64'd1);
    tick();
    send(64'hA1B2_C3D4_E5F6_0708, 4'b1010, 8'd5, a);
    @(negedge clk);
    chk("t3_lenErr", 64'(lenErr), 64'd1);
    drain();

    // Back-pressure in EMIT0
    outReady = 1'b0;
    send(64'h4567_89AB_CDEF_0000, 4'b1011, 8'd6, a);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_valid",   64'(outValid), 64'd1);
      chk("t4_stall_data",    64'(dataOut),  64'h4567_0000);
      chk("t4_stall_inReady", 64'(inReady),  64'd0);
      tick();
    end
    outReady = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_field1", 64'(dataOut), 64'h89AB_CDEF);
    drain();

    // Reset while EMIT1 is pending
    outReady = 1'b0;
    send(64'h1122_3344_5566_7788, 4'b1111, 8'd8, a);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    reset = 1'b1;
    expq.delete();
    tick();
    reset = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    chk("t5_valid",   64'(outValid), 64'd0);
    chk("t5_inReady", 64'(inReady),  64'd1);
    for (int k = 0; k < 4; k++) tick();

    // Back-to-back random words, full throughput
    first_acc = 0;
    last_acc  = 0;
    exp_span  = 0;
    for (int w = 0; w < 1000; w++) begin
      rand_word(d, t, l);
      send(d, t, l, a);
      if (w == 0) first_acc = a;
      if (w < 999) exp_span += 1 + int'(tlen(t[3:2]) != 0) + int'(tlen(t[1:0]) != 0);
      last_acc = a;
    end
    chk("t6_throughput", 64'(last_acc - first_acc), 64'(exp_span));
    drain();

    // Random words under random back-pressure
    rnd_ready = 1'b1;
    for (int w = 0; w < 300; w++) begin
      rand_word(d, t, l);
      send(d, t, l, a);
    end
    rnd_ready = 1'b0;
    outReady = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
